// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encoding, converter state encoding and
// exponent bias helpers, common to the int-to-float and float-to-int paths.
package fpu_pkg;

   localparam logic [1:0] RND_ZERO    = 2'b00;
   localparam logic [1:0] RND_NEGINF  = 2'b01;
   localparam logic [1:0] RND_POSINF  = 2'b10;
   localparam logic [1:0] RND_NEAREST = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ABS   = 2'd1,
      ST_NORM  = 2'd2,
      ST_ROUND = 2'd3
   } state_e;

   // Bias is all ones over exponent_size-1 bits.
   function automatic int bias_for(input int exp_bits);
      return (1 << (exp_bits - 1)) - 1;
   endfunction

   localparam int DEFAULT_EXP_BIAS = bias_for(8);

endpackage

// File: rtl/leading_one_detector.sv
// Combinational priority encoder: position of the most significant set bit.
// An all-zero input reports position 0; callers detect zero separately.
module leading_one_detector #(
   parameter int WIDTH = 64,
   localparam int PW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [PW-1:0]    pos_o
);

   always_comb begin
      pos_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec_i[i]) pos_o = PW'(i);
      end
   end

endmodule

// File: rtl/int_to_floating_point.sv
// Signed integer to binary float converter, 3-cycle latency, start/done framed.
// Stages: capture (IDLE) -> magnitude (ABS) -> normalise (NORM) -> round (ROUND).
module int_to_floating_point
   import fpu_pkg::*;
#(
   parameter int int_size      = 64,
   parameter int mantissa_size = 23,
   parameter int exponent_size = 8,
   parameter int precision     = 1 + exponent_size + mantissa_size,
   parameter int exp_bias      = bias_for(exponent_size)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [int_size-1:0]  int_i,
   input  logic [1:0]           conv_i,
   output logic [precision-1:0] float_o,
   output logic                 inexact_flag_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int PW = $clog2(int_size);
   localparam logic [int_size-1:0] ONES        = '1;
   localparam logic [int_size-1:0] STICKY_MASK = ONES >> (mantissa_size + 2);

   state_e                   state_q, state_d;
   logic                     sign_q, sign_d;
   logic [1:0]               conv_q, conv_d;
   logic [int_size-1:0]      val_q, val_d;
   logic [exponent_size-1:0] exp_q, exp_d;
   logic [precision-1:0]     float_q, float_d;
   logic                     inexact_q, inexact_d;
   logic                     done_q, done_d;

   logic [PW-1:0]            lead_pos;
   logic [mantissa_size-1:0] frac;
   logic [mantissa_size:0]   frac_inc;
   logic                     guard, sticky, round_up;
   logic [exponent_size-1:0] exp_rnd;

   leading_one_detector #(.WIDTH(int_size)) u_lod (
      .vec_i (val_q),
      .pos_o (lead_pos)
   );

   // After NORM the leading one sits at the MSB; fields are read below it.
   always_comb begin
      frac     = val_q[int_size-2 -: mantissa_size];
      guard    = val_q[int_size-2-mantissa_size];
      sticky   = |(val_q & STICKY_MASK);
      round_up = 1'b0;
      unique case (conv_q)
         RND_ZERO:   round_up = 1'b0;
         RND_NEGINF: round_up = sign_q & (guard | sticky);
         RND_POSINF: round_up = ~sign_q & (guard | sticky);
         default:    round_up = guard & (sticky | frac[0]);
      endcase
      frac_inc = {1'b0, frac} + (mantissa_size+1)'(round_up);
      exp_rnd  = exp_q + exponent_size'(frac_inc[mantissa_size]);
   end

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      conv_d    = conv_q;
      val_d     = val_q;
      exp_d     = exp_q;
      float_d   = float_q;
      inexact_d = inexact_q;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sign_d  = int_i[int_size-1];
               val_d   = int_i;
               conv_d  = conv_i;
               state_d = ST_ABS;
            end
         end
         ST_ABS: begin
            // Unsigned view makes the most negative integer come out as 2^(int_size-1).
            val_d   = sign_q ? -val_q : val_q;
            state_d = ST_NORM;
         end
         ST_NORM: begin
            val_d   = val_q << (PW'(int_size - 1) - lead_pos);
            exp_d   = exponent_size'(exp_bias) + exponent_size'(lead_pos);
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            if (val_q[int_size-1]) begin
               float_d   = {sign_q, exp_rnd, frac_inc[mantissa_size-1:0]};
               inexact_d = guard | sticky;
            end else begin
               float_d   = '0;
               inexact_d = 1'b0;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         sign_q    <= 1'b0;
         conv_q    <= 2'b00;
         val_q     <= '0;
         exp_q     <= '0;
         float_q   <= '0;
         inexact_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         conv_q    <= conv_d;
         val_q     <= val_d;
         exp_q     <= exp_d;
         float_q   <= float_d;
         inexact_q <= inexact_d;
         done_q    <= done_d;
      end
   end

   assign float_o        = float_q;
   assign inexact_flag_o = inexact_q;
   assign done_o         = done_q;
   assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_int_to_floating_point.sv
// Bench for int_to_floating_point: arithmetic reference model plus a per-cycle
// scoreboard compare, driven by directed vectors with literal expectations.
module tb_int_to_floating_point;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic [63:0] int_i = '0;
   logic [1:0]  conv_i = 2'b00;
   logic [31:0] float_o;
   logic        inexact_flag_o, busy_o, done_o;

   int_to_floating_point dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .int_i          (int_i),
      .conv_i         (conv_i),
      .float_o        (float_o),
      .inexact_flag_o (inexact_flag_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_pass = 0;
   int n_done = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference: quantise |x| onto multiples of ulp = 2^(e-23), then round by mode.
   function automatic void model(input logic [63:0] x, input logic [1:0] md,
                                 output logic [31:0] f, output logic inx);
      logic        s, up;
      logic [63:0] m, ulp, lo, rem;
      int          e;
      f   = '0;
      inx = 1'b0;
      s   = x[63];
      m   = s ? -x : x;
      if (m == 64'd0) return;
      e = 63;
      while (!m[e]) e--;
      if (e <= 23) begin
         lo  = m << (23 - e);
         rem = 64'd0;
         ulp = 64'd1;
      end else begin
         ulp = 64'd1 << (e - 23);
         lo  = m / ulp;
         rem = m % ulp;
      end
      inx = (rem != 64'd0);
      case (md)
         2'd0:    up = 1'b0;
         2'd1:    up = s && inx;
         2'd2:    up = !s && inx;
         default: up = (2 * rem > ulp) || ((2 * rem == ulp) && lo[0]);
      endcase
      if (up) lo = lo + 64'd1;
      if (lo == (64'd1 << 24)) begin
         lo = 64'd1 << 23;
         e++;
      end
      f = {s, 8'(e + 127), lo[22:0]};
   endfunction

   typedef struct packed {
      int unsigned due;
      logic [31:0] f;
      logic        inex;
   } exp_t;

   exp_t        pend[$];
   int unsigned cyc = 0;
   int unsigned next_ok = 0;
   logic [31:0] hold_f = '0;
   logic        hold_x = 1'b0;

   // Acceptance model: an idle converter takes start, then is deaf for 4 edges.
   always @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pend.delete();
         next_ok = 0;
         hold_f  = '0;
         hold_x  = 1'b0;
      end else begin
         logic [31:0] mf;
         logic        mx;
         exp_t        ent;
         cyc = cyc + 1;
         if (start_i && cyc >= next_ok) begin
            model(int_i, conv_i, mf, mx);
            ent.due  = cyc + 3;
            ent.f    = mf;
            ent.inex = mx;
            pend.push_back(ent);
            next_ok = cyc + 4;
         end
      end
   end

   always @(negedge clk_i) begin
      logic ed, eb;
      ed = (pend.size() > 0) && (pend[0].due == cyc);
      eb = (pend.size() > 0) && (cyc < pend[0].due);
      if (ed) begin
         hold_f = pend[0].f;
         hold_x = pend[0].inex;
         void'(pend.pop_front());
      end
      if (done_o) n_done++;
      chk("cyc_done", done_o, ed);
      chk("cyc_busy", busy_o, eb);
      chk("cyc_float", float_o, hold_f);
      chk("cyc_inexact", inexact_flag_o, hold_x);
   end

   task automatic run(input logic [63:0] x, input logic [1:0] md,
                      input logic [31:0] ef, input logic ex);
      logic [31:0] mf;
      logic        mx;
      model(x, md, mf, mx);
      chk("model_float", mf, ef);
      chk("model_inexact", mx, ex);
      @(posedge clk_i); #2;
      start_i = 1'b1; int_i = x; conv_i = md;
      @(posedge clk_i); #2;
      start_i = 1'b0; int_i = {$urandom, $urandom}; conv_i = 2'($urandom);
      @(posedge clk_i);
      @(posedge clk_i);
      @(posedge clk_i); #1;
      chk("dut_float", float_o, ef);
      chk("dut_inexact", inexact_flag_o, ex);
      chk("dut_done_at_3", done_o, 1'b1);
   endtask

   typedef struct packed {
      logic [63:0] x;
      logic [1:0]  md;
      logic [31:0] f;
      logic        inx;
   } vec_t;

   vec_t vecs[] = '{
      '{64'd1,                   2'd3, 32'h3F800000, 1'b0},
      '{-64'd1,                  2'd3, 32'hBF800000, 1'b0},
      '{64'd0,                   2'd3, 32'h00000000, 1'b0},
      '{64'd0,                   2'd1, 32'h00000000, 1'b0},
      '{64'd5,                   2'd3, 32'h40A00000, 1'b0},
      '{64'd100,                 2'd2, 32'h42C80000, 1'b0},
      '{-64'd7,                  2'd0, 32'hC0E00000, 1'b0},
      '{64'd16777217,            2'd3, 32'h4B800000, 1'b1},
      '{64'd16777217,            2'd2, 32'h4B800001, 1'b1},
      '{64'd16777217,            2'd0, 32'h4B800000, 1'b1},
      '{64'h8000000000000000,    2'd0, 32'hDF000000, 1'b0},
      '{64'h8000000000000000,    2'd1, 32'hDF000000, 1'b0},
      '{64'h8000000000000000,    2'd2, 32'hDF000000, 1'b0},
      '{64'h8000000000000000,    2'd3, 32'hDF000000, 1'b0},
      '{64'h7FFFFFFFFFFFFFFF,    2'd3, 32'h5F000000, 1'b1},
      '{64'h7FFFFFFFFFFFFFFF,    2'd0, 32'h5EFFFFFF, 1'b1},
      '{-64'd16777219,           2'd1, 32'hCB800002, 1'b1},
      '{-64'd16777219,           2'd2, 32'hCB800001, 1'b1},
      '{-64'd16777219,           2'd3, 32'hCB800002, 1'b1}
   };

   initial begin
      int n0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_float", float_o, 32'h0);
      chk("reset_inexact", inexact_flag_o, 1'b0);
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_done", done_o, 1'b0);
      #1 reset_i = 1'b0;

      foreach (vecs[i]) run(vecs[i].x, vecs[i].md, vecs[i].f, vecs[i].inx);

      // start held high: only every fourth edge may accept
      @(posedge clk_i); #2;
      n0 = n_done;
      start_i = 1'b1; int_i = 64'd5; conv_i = 2'd3;
      repeat (16) @(posedge clk_i);
      #2 start_i = 1'b0;
      repeat (6) @(posedge clk_i);
      chk("held_start_dones", n_done - n0, 4);

      // reset one cycle into a conversion: aborted, no done
      @(posedge clk_i); #2;
      start_i = 1'b1; int_i = 64'd100; conv_i = 2'd3;
      @(posedge clk_i); #2;
      start_i = 1'b0;
      @(posedge clk_i); #2;
      reset_i = 1'b1;
      #1;
      chk("abort_float", float_o, 32'h0);
      chk("abort_busy", busy_o, 1'b0);
      @(posedge clk_i); #2;
      reset_i = 1'b0;
      n0 = n_done;
      repeat (4) @(posedge clk_i);
      chk("abort_no_done", n_done - n0, 0);
      run(-64'd7, 2'd0, 32'hC0E00000, 1'b0);

      for (int i = 0; i < 20 && pend.size() > 0; i++) @(posedge clk_i);
      chk("drain", pend.size(), 0);
      @(negedge clk_i);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/int_to_floating_point.md
# int_to_floating_point

Sequential converter from a two's-complement signed integer to an IEEE-754-style binary float. It is the reverse path of the float-to-integer unit in the FPU. A start/done handshake frames each conversion, and the rounding mode is selectable per conversion with the same `conv` encoding the float-to-int path uses. Fixed latency is 3 cycles. Throughput is one conversion per 4 cycles.

## Interface
- `int_size`, 64: integer input width; must be ≥ `mantissa_size` + 2.
- `mantissa_size`, 23: stored fraction bits.
- `exponent_size`, 8: exponent bits.
- `precision`, 32: float width, equal to 1 + `exponent_size` + `mantissa_size`.
- `exp_bias`, all ones over `exponent_size` − 1 bits (127): exponent bias.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `int`  in  `int_size`: signed operand; captured on the accepted `start`.
- `conv`  in  2: rounding mode, captured with `int`.
  - 00 = toward zero.
  - 01 = toward −inf.
  - 10 = toward +inf.
  - 11 = nearest, ties to even.
- `float`  out  `precision`: result, held until the next result is written.
- `inexact_flag`  out  1: high when the result ≠ `int`; held with `float`.
- `busy`  out  1: high in ABS, NORM and ROUND.
- `done`  out  1: single-cycle pulse in the cycle `float` first shows a new result.

## Operation
- State machine states:
  - IDLE: on `start`, register sign = `int`[MSB], the operand and `conv`, then go to ABS.
  - ABS: magnitude = operand, negated if the sign is set. Treat it as unsigned `int_size` bits, so the most negative integer gives 2^(int_size−1). Go to NORM.
  - NORM: find p, the position of the leading one (via a sub-module). Left-shift the magnitude so that leading one sits at bit `int_size`−1. Biased exponent = p + `exp_bias`. Go to ROUND.
  - ROUND:
    - Split the shifted value below the leading one into:
      - fraction = the next `mantissa_size` bits;
      - guard = the next bit;
      - sticky = OR of all remaining bits.
    - Round up when:
      - 00: never.
      - 01: sign & (guard | sticky).
      - 10: !sign & (guard | sticky).
      - 11: guard & (sticky | fraction LSB).
    - If incrementing the fraction carries out, the fraction becomes 0 and the exponent increments by 1.
    - Write `float` = {sign, exponent, fraction} and `inexact_flag` = guard | sticky.
    - Pulse `done` and return to IDLE.
- A magnitude of zero gives `float` = all zeros (+0.0) and `inexact_flag` = 0, in every mode.
- Overflow is impossible for the legal parameter ranges, so there is no overflow or invalid flag.

## Timing
- Reset values: `float` = 0, `inexact_flag` = 0, `done` = 0, `busy` = 0, state = IDLE. Internal registers are cleared too.
- Accept at edge k. ABS at k, NORM at k+1, ROUND at k+2. `float`, `inexact_flag` and `done` update at edge k+3.
- `done` is high for exactly one cycle. It clears at edge k+4 unless a new result is written then, which is impossible at this throughput.
- `start` is ignored while `busy`. Changes to `int` or `conv` after the accept have no effect on the conversion in flight.
- The earliest next accept is edge k+3 + 1.
- `reset` asserted mid-conversion aborts it immediately:
  - outputs return to their reset values;
  - no `done` pulse is produced;
  - the first `start` after reset release is accepted normally.

## Structure
- Shared package `fpu_pkg`:
  - rounding-mode constants RND_ZERO, RND_NEGINF, RND_POSINF, RND_NEAREST (shared with the float-to-int unit);
  - state encoding;
  - the default bias constant.
- Sub-module `leading_one_detector`: a combinational priority encoder, `int_size` in, clog2(`int_size`) out, used in NORM.

## Test plan
- Small exact values, mode 11:
  - `int` = 1 → `float` 0x3F800000, inexact 0, `done` at cycle 3.
  - `int` = −1 → 0xBF800000.
  - `int` = 0 → 0x00000000.
- `int` = 16777217 (2^24 + 1), ties case:
  - mode 11 → 0x4B800000, inexact 1;
  - mode 10 → 0x4B800001;
  - mode 00 → 0x4B800000.
- `int` = −2^63 → 0xDF000000, inexact 0, in all modes.
- `int` = 2^63 − 1:
  - mode 11 → 0x5F000000, the rounding carry bumps the exponent;
  - mode 00 → 0x5EFFFFFF, inexact 1.
- Negative rounding: `int` = −16777219 (−(2^24 + 3)):
  - mode 01 → 0xCB800002;
  - mode 10 → 0xCB800001.
- Handshake and reset:
  - `start` held high continuously → exactly one accept per 4 cycles.
  - `reset` pulsed at cycle 1 of a conversion → no `done`, outputs 0, and the next conversion is correct.
